// File: rtl/mxbus_pkg.sv
// Shared types and constants for the MX bus memory responder.
//   state_e     : responder FSM states (idle, acknowledge, wait-state)
//   owner_e     : which channel owns the in-flight transaction
//   MAX_LATENCY : largest supported ack-to-cpl wait count
//   CNT_W       : width of the wait-state counter
package mxbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } owner_e;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/mxbus_sp_ram.sv
// Single-port synchronous word RAM with registered read.
//   clk, rst_n : clock, async active-low reset (read register only)
//   en, we     : access enable, write enable (en & ~we is a read)
//   addr       : word address; addresses >= DEPTH drop writes, read as 0
//   wdata      : write data
//   rdata      : registered read data, holds until the next read
module mxbus_sp_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  always_comb begin
    in_range = 32'(addr) < 32'(DEPTH);
    idx      = addr[IDX_W-1:0];
    rdata_d  = rdata_q;
    if (en && !we) begin
      rdata_d = in_range ? mem_q[idx] : '0;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mxbus_mem_responder.sv
// MX bus responder: one read channel and one write channel serviced
// one transaction at a time against a single-port word memory.
//   clk, rst_n       : clock, async active-low reset
//   s0_rd_*          : read channel (start/addr in; ready/ack/cpl/data out)
//   s0_wr_*          : write channel (start/addr/data in; ready/ack/cpl out)
// ack pulses the cycle after a start is sampled; cpl follows LATENCY cycles
// later (same cycle as ack when LATENCY=0). Contended starts are granted
// round-robin, read first after reset.
module mxbus_mem_responder
  import mxbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_rd_txn_start,
  input  logic [ADDR_WIDTH-1:0] s0_rd_addr,
  output logic                  s0_rd_ready,
  output logic                  s0_rd_txn_ack,
  output logic                  s0_rd_txn_cpl,
  output logic [DATA_WIDTH-1:0] s0_rd_data,
  input  logic                  s0_wr_txn_start,
  input  logic [ADDR_WIDTH-1:0] s0_wr_addr,
  input  logic [DATA_WIDTH-1:0] s0_wr_data,
  output logic                  s0_wr_ready,
  output logic                  s0_wr_txn_ack,
  output logic                  s0_wr_txn_cpl
);

  state_e                state_d, state_q;
  owner_e                owner_d, owner_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  last_rd_d, last_rd_q;
  logic                  rd_ack_d, rd_ack_q, rd_cpl_d, rd_cpl_q;
  logic                  wr_ack_d, wr_ack_q, wr_cpl_d, wr_cpl_q;
  logic                  ready_d, ready_q;

  logic                  grant_rd;
  logic                  fire_cpl;
  logic                  mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    rd_ack_d  = 1'b0;
    rd_cpl_d  = 1'b0;
    wr_ack_d  = 1'b0;
    wr_cpl_d  = 1'b0;
    fire_cpl  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    // Read loses only when both request and read won the last contention.
    grant_rd  = s0_rd_txn_start && !(s0_wr_txn_start && last_rd_q);

    unique case (state_q)
      ST_IDLE: begin
        if (s0_rd_txn_start || s0_wr_txn_start) begin
          owner_d  = grant_rd ? OWN_RD : OWN_WR;
          // Round-robin pointer only moves on contention.
          if (s0_rd_txn_start && s0_wr_txn_start) begin
            last_rd_d = grant_rd;
          end
          addr_d   = grant_rd ? s0_rd_addr : s0_wr_addr;
          wdata_d  = s0_wr_data;
          cnt_d    = CNT_W'(LATENCY);
          rd_ack_d = grant_rd;
          wr_ack_d = !grant_rd;
          state_d  = ST_ACK;
          if (LATENCY == 0) begin
            // Zero wait states: memory op uses the live request, not the latch.
            fire_cpl = 1'b1;
            mem_addr = addr_d;
            mem_wdata = wdata_d;
          end
        end
      end
      ST_ACK: begin
        if (LATENCY == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_WAIT;
          cnt_d    = cnt_q - 1'b1;
          fire_cpl = (cnt_q == CNT_W'(1));
        end
      end
      ST_WAIT: begin
        // cnt reaches 0 on the cpl edge; the following edge returns to idle.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          fire_cpl = (cnt_q == CNT_W'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire_cpl) begin
      rd_cpl_d = (owner_d == OWN_RD);
      wr_cpl_d = (owner_d == OWN_WR);
      // No memory access can land while reset is held.
      mem_en   = rst_n;
      mem_we   = (owner_d == OWN_WR);
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_cpl_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      wr_cpl_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      rd_ack_q  <= rd_ack_d;
      rd_cpl_q  <= rd_cpl_d;
      wr_ack_q  <= wr_ack_d;
      wr_cpl_q  <= wr_cpl_d;
      ready_q   <= ready_d;
    end
  end

  mxbus_sp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (s0_rd_data)
  );

  assign s0_rd_ready   = ready_q;
  assign s0_wr_ready   = ready_q;
  assign s0_rd_txn_ack = rd_ack_q;
  assign s0_rd_txn_cpl = rd_cpl_q;
  assign s0_wr_txn_ack = wr_ack_q;
  assign s0_wr_txn_cpl = wr_cpl_q;

endmodule
